// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the peripheral register bus.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 8;
  localparam int unsigned BUS_DATA_W = 32;

  // Width of the read latency down-counter; covers latencies 1..15.
  localparam int unsigned LAT_CNT_W = 4;

  // Register offsets decoded by peripheral slaves (bits [3:2]).
  localparam logic [BUS_ADDR_W-1:0] REG_CTRL   = 8'h00;
  localparam logic [BUS_ADDR_W-1:0] REG_STATE1 = 8'h04;
  localparam logic [BUS_ADDR_W-1:0] REG_STATE2 = 8'h08;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_cmd_master.sv
// bus_cmd_master: turns one valid/ready command at a time into a single-cycle
// read or write strobe on the peripheral bus and returns read data on a
// valid/ready response port. All outputs are registered.
// Optional: define BUS_CMD_MASTER_WRITE_ACK_EN to also return a response
// (rsp_is_write = 1, rsp_rdata = 0) for every write.
module bus_cmd_master
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = BUS_ADDR_W,
  parameter int unsigned DATA_W       = BUS_DATA_W,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              pclk,
  input  logic              nreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_is_write,
  output logic              busy,
  output logic              bus_write_en,
  output logic              bus_read_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write_data,
  input  logic [DATA_W-1:0] bus_read_data
);

  // Counter load value: WAIT lasts READ_LATENCY cycles, sampling when it hits 0.
  localparam logic [LAT_CNT_W-1:0] CntInit = LAT_CNT_W'(READ_LATENCY - 1);

  bus_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
`ifdef BUS_CMD_MASTER_WRITE_ACK_EN
  logic                 is_write_q, is_write_d;
`endif

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef BUS_CMD_MASTER_WRITE_ACK_EN
  // Response type flag, only present when writes are acknowledged.
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      is_write_q <= 1'b0;
    end else begin
      is_write_q <= is_write_d;
    end
  end
`endif

  // Next-state and next-output logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
`ifdef BUS_CMD_MASTER_WRITE_ACK_EN
    is_write_d  = is_write_q;
`endif
    case (state_q)
      StIdle: begin
        // cmd_ready_q is low for the first cycle after reset, so gate on it.
        if (cmd_valid && cmd_ready_q) begin
          state_d = StStrobe;
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wr_en_d = cmd_write;
          rd_en_d = !cmd_write;
        end
      end
      StStrobe: begin
        if (write_q) begin
`ifdef BUS_CMD_MASTER_WRITE_ACK_EN
          state_d     = StResp;
          rdata_d     = '0;
          is_write_d  = 1'b1;
          rsp_valid_d = 1'b1;
`else
          state_d     = StIdle;
`endif
        end else begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rdata_d     = bus_read_data;
          rsp_valid_d = 1'b1;
`ifdef BUS_CMD_MASTER_WRITE_ACK_EN
          is_write_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign bus_write_en   = wr_en_q;
  assign bus_read_en    = rd_en_q;
  assign bus_addr       = addr_q;
  assign bus_write_data = wdata_q;
`ifdef BUS_CMD_MASTER_WRITE_ACK_EN
  assign rsp_is_write   = is_write_q;
`else
  assign rsp_is_write   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cmd_master.sv
// tb_bus_cmd_master: table-driven, hand-written and randomized checks of
// bus_cmd_master against a slave model and a register-array reference.
`timescale 1ns/1ps
module tb_bus_cmd_master;

`ifdef BUS_CMD_MASTER_WRITE_ACK_EN
  localparam bit Ack = 1'b1;
`else
  localparam bit Ack = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        nreset;
  always #5 pclk = ~pclk;

  // Main DUT, READ_LATENCY = 1
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_is_write, busy;
  logic [31:0] rsp_rdata;
  logic        bus_write_en, bus_read_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = '0;

  // Second DUT, READ_LATENCY = 3
  logic        l3_cmd_valid, l3_cmd_ready, l3_cmd_write;
  logic [7:0]  l3_cmd_addr;
  logic [31:0] l3_cmd_wdata;
  logic        l3_rsp_valid, l3_rsp_ready, l3_rsp_is_write, l3_busy;
  logic [31:0] l3_rsp_rdata;
  logic        l3_bus_write_en, l3_bus_read_en;
  logic [7:0]  l3_bus_addr;
  logic [31:0] l3_bus_write_data;
  logic [31:0] l3_bus_read_data = '0;

  bus_cmd_master #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) u_dut (
    .pclk(pclk), .nreset(nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_is_write(rsp_is_write), .busy(busy),
    .bus_write_en(bus_write_en), .bus_read_en(bus_read_en), .bus_addr(bus_addr),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data)
  );

  bus_cmd_master #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(3)) u_dut3 (
    .pclk(pclk), .nreset(nreset),
    .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready), .cmd_write(l3_cmd_write),
    .cmd_addr(l3_cmd_addr), .cmd_wdata(l3_cmd_wdata),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_rdata(l3_rsp_rdata),
    .rsp_is_write(l3_rsp_is_write), .busy(l3_busy),
    .bus_write_en(l3_bus_write_en), .bus_read_en(l3_bus_read_en), .bus_addr(l3_bus_addr),
    .bus_write_data(l3_bus_write_data), .bus_read_data(l3_bus_read_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Bus access record: {write, addr, wdata}
  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;

  acc_t        bus_q[$];
  acc_t        exp_q[$];
  logic [31:0] rsp_log[$];
  logic [31:0] ref_mem[4];

  // Slave register file behind the main DUT, decoding addr[3:2].
  logic [31:0] slave_mem[4] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};

  always @(posedge pclk) begin
    if (bus_write_en) begin
      slave_mem[bus_addr[3:2]] <= bus_write_data;
      bus_q.push_back(acc_t'({1'b1, bus_addr, bus_write_data}));
    end
    if (bus_read_en) begin
      bus_read_data <= slave_mem[bus_addr[3:2]];
      bus_q.push_back(acc_t'({1'b0, bus_addr, 32'h0}));
    end
    if (nreset && rsp_valid && rsp_ready) rsp_log.push_back(rsp_rdata);
  end

  always @(posedge pclk) begin
    if (l3_bus_read_en)
      l3_bus_read_data <= (l3_bus_addr[3:2] == 2'd2) ? 32'h1234_5678 : 32'h0;
  end

  // Strobes never overlap and never last two consecutive cycles.
  logic prev_strobe = 1'b0;
  always @(negedge pclk) begin
    if (nreset && (bus_write_en || bus_read_en)) begin
      chk("strobe_overlap", {bus_write_en, bus_read_en} == 2'b11, 1'b0);
      chk("strobe_back_to_back", prev_strobe, 1'b0);
    end
    prev_strobe <= bus_write_en | bus_read_en;
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_is_write, busy, bus_write_en, bus_read_en}, 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_data"}, {rsp_rdata, bus_write_data}, 0);
  endtask

  task automatic cmp_logs(input string tag);
    int n;
    chk({tag, "_bus_len"}, bus_q.size(), exp_q.size());
    n = (bus_q.size() < exp_q.size()) ? bus_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_bus_entry"}, bus_q[i], exp_q[i]);
    bus_q.delete();
    exp_q.delete();
  endtask

  // One command on the main DUT, starting at a negedge with cmd_ready high.
  task automatic txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     input int stall, input logic [31:0] exp_d);
    int k, r, rdy, exp_r, exp_rdy;
    logic seen_strobe;
    exp_q.push_back(acc_t'({wr, a, wr ? d : 32'h0}));
    if (wr) ref_mem[a[3:2]] = d;
    exp_r   = wr ? (Ack ? 2 : -1) : 3;
    exp_rdy = (exp_r < 0) ? 2 : exp_r + stall + 1;
    chk("pre_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    rsp_ready = (stall == 0);
    k = 0; r = -1; rdy = -1; seen_strobe = 1'b0;
    while (k < 40 && rdy < 0) begin
      @(negedge pclk); k++;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
      if (bus_write_en || bus_read_en) begin
        seen_strobe = 1'b1;
        chk("strobe_cycle", k, 1);
        chk("strobe_kind", bus_write_en, wr);
        chk("strobe_addr", bus_addr, a);
        if (wr) chk("strobe_wdata", bus_write_data, d);
        chk("busy_in_strobe", busy, 1'b1);
      end
      if (rsp_valid && r < 0) begin
        r = k;
        chk("rsp_cycle", k, exp_r);
        chk("rsp_rdata", rsp_rdata, exp_d);
        chk("rsp_is_write", rsp_is_write, wr);
        for (int s = 0; s < stall; s++) begin
          @(negedge pclk); k++;
          chk("stall_hold", {rsp_valid, cmd_ready, bus_write_en, bus_read_en, rsp_rdata},
              {4'b1000, exp_d});
        end
        rsp_ready = 1'b1;
      end else if (cmd_ready) begin
        rdy = k;
      end
    end
    chk("ready_cycle", rdy, exp_rdy);
    chk("strobe_seen", seen_strobe, 1'b1);
    chk("rsp_seen", r >= 0, exp_r >= 0);
    chk("rsp_dropped", {rsp_valid, busy}, 2'b00);
  endtask

  // Read on the latency-3 DUT: strobe at +1, response at +5, ready at +6.
  task automatic l3_read(input logic [7:0] a, input logic [31:0] exp_d);
    int s = -1, r = -1, rdy = -1;
    chk("l3_pre_ready", l3_cmd_ready, 1'b1);
    l3_cmd_valid = 1'b1; l3_cmd_write = 1'b0; l3_cmd_addr = a;
    for (int k = 1; k <= 30 && rdy < 0; k++) begin
      @(negedge pclk);
      l3_cmd_valid = 1'b0;
      if (l3_bus_read_en && s < 0) s = k;
      if (l3_rsp_valid && r < 0) begin
        r = k;
        chk("l3_rsp_rdata", l3_rsp_rdata, exp_d);
      end else if (l3_cmd_ready) begin
        rdy = k;
      end
    end
    chk("l3_strobe_cycle", s, 1);
    chk("l3_rsp_cycle", r, 5);
    chk("l3_ready_cycle", rdy, 6);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t        tbl[8];
    logic        bw[8];
    logic [7:0]  ba[8];
    logic [31:0] bd[8];
    logic [31:0] exp_rd[$];
    int          idx, cyc;
    logic        acc, seen;

    tbl[0] = '{1'b1, 8'h04, 32'h80FF_0000, 0, 32'h0};
    tbl[1] = '{1'b1, 8'h08, 32'h1234_5678, 0, 32'h0};
    tbl[2] = '{1'b0, 8'h08, 32'h0,         0, 32'h1234_5678};
    tbl[3] = '{1'b0, 8'h04, 32'h0,         5, 32'h80FF_0000};
    tbl[4] = '{1'b0, 8'h0C, 32'h0,         1, 32'h1000_0003};
    tbl[5] = '{1'b1, 8'h00, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[6] = '{1'b0, 8'h00, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[7] = '{1'b0, 8'h31, 32'h0,         2, 32'hDEAD_BEEF};

    for (int i = 0; i < 4; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);

    nreset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    l3_cmd_valid = 1'b0; l3_cmd_write = 1'b0; l3_cmd_addr = '0; l3_cmd_wdata = '0;
    l3_rsp_ready = 1'b1;

    repeat (3) @(negedge pclk);
    check_all_zero("reset_state");
    chk("l3_reset_ctl", {l3_cmd_ready, l3_rsp_valid, l3_rsp_is_write, l3_busy,
                         l3_bus_write_en, l3_bus_read_en}, 0);
    chk("l3_reset_data", {l3_rsp_rdata, l3_bus_write_data}, 0);
    nreset = 1'b1;
    @(negedge pclk);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].stall, tbl[i].exp_rdata);
    end
    cmp_logs("table");

    // Randomized commands against the register-array reference
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [7:0]  a;
      logic [31:0] d;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      d  = $urandom;
      txn(wr, a, d, $urandom_range(0, 3), wr ? 32'h0 : ref_mem[a[3:2]]);
    end
    cmp_logs("random");

    // cmd_valid held high with alternating write/read commands
    rsp_log.delete();
    for (int i = 0; i < 8; i++) begin
      bw[i] = (i % 2 == 0);
      ba[i] = 8'($urandom);
      bd[i] = $urandom;
      exp_q.push_back(acc_t'({bw[i], ba[i], bw[i] ? bd[i] : 32'h0}));
      if (bw[i]) begin
        ref_mem[ba[i][3:2]] = bd[i];
        if (Ack) exp_rd.push_back(32'h0);
      end else begin
        exp_rd.push_back(ref_mem[ba[i][3:2]]);
      end
    end
    idx = 0; cyc = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = bw[0]; cmd_addr = ba[0]; cmd_wdata = bd[0];
    while (idx < 8 && cyc < 200) begin
      acc = cmd_ready;
      @(negedge pclk); cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) begin
          cmd_write = bw[idx]; cmd_addr = ba[idx]; cmd_wdata = bd[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_all_accepted", idx, 8);
    repeat (6) @(negedge pclk);
    chk("b2b_idle", cmd_ready, 1'b1);
    chk("b2b_rsp_len", rsp_log.size(), exp_rd.size());
    for (int i = 0; i < rsp_log.size() && i < exp_rd.size(); i++)
      chk("b2b_rsp_data", rsp_log[i], exp_rd[i]);
    cmp_logs("b2b");

    // Reset pulsed during the read strobe, then during WAIT
    for (int kr = 1; kr <= 2; kr++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
      @(negedge pclk);
      cmd_valid = 1'b0;
      if (kr == 2) @(negedge pclk);
      #1 nreset = 1'b0;
      #1 check_all_zero("async_reset");
      @(negedge pclk);
      nreset = 1'b1;
      seen = 1'b0;
      repeat (6) begin
        @(negedge pclk);
        if (rsp_valid) seen = 1'b1;
      end
      chk("no_rsp_after_reset", seen, 1'b0);
    end
    bus_q.delete();
    exp_q.delete();
    txn(1'b0, 8'h08, 32'h0, 0, ref_mem[2]);
    cmp_logs("post_reset");

    // Latency-3 instance: two back-to-back reads
    l3_read(8'h08, 32'h1234_5678);
    l3_read(8'h08, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_cmd_master.md
Name: bus_cmd_master

Overview:
- Initiator side of the peripheral register bus: turns one command at a time, taken from a valid/ready command port, into a single-cycle read or write strobe on the shared peripheral bus.
- Read data is captured after a fixed bus read latency and returned on a valid/ready response port.
- Sits between the command source (SPI/host bridge or sequencer) and peripheral slaves such as the RGB LED controller.

Parameters:
- ADDR_W, 8: bus address width.
- DATA_W, 32: bus data width.
- READ_LATENCY, 1: cycles from the read strobe cycle to the edge where bus_read_data is sampled; legal range 1..15.

Ports:
- pclk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; slaves decode [3:2].
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data.
- rsp_is_write  out  1  response belongs to a write (ACK feature only; otherwise 0).
- busy  out  1  high in any state other than IDLE.
- bus_write_en  out  1  write strobe.
- bus_read_en  out  1  read strobe.
- bus_addr  out  ADDR_W  bus address.
- bus_write_data  out  DATA_W  bus write data.
- bus_read_data  in  DATA_W  slave read data (registered by slave).

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0; asynchronous assertion, synchronous deassertion of effect on the next pclk edge.
- All outputs are registered; cmd_ready = (state == IDLE).
- States:
  - IDLE: on cmd_valid, latch addr, wdata and write; go to STROBE.
  - STROBE: exactly one cycle with bus_write_en or bus_read_en = 1. A write goes to IDLE; a read goes to WAIT with cnt = READ_LATENCY-1.
  - WAIT: at the edge where cnt == 0, sample bus_read_data into rsp_rdata and go to RESP; otherwise decrement cnt.
  - RESP: rsp_valid = 1, held stable until rsp_ready; on handshake go to IDLE.
- bus_addr and bus_write_data are driven from the latched command from STROBE onward and hold their value until the next accept; they never change while a strobe is high.
- bus_write_en and bus_read_en are never high together and never high for more than one consecutive cycle.
- Throughput:
  - Write: one per 2 cycles.
  - Read: 3 + READ_LATENCY cycles minimum, excluding response stall.
- Boundaries:
  - rsp_ready held low: stays in RESP indefinitely, no bus activity, cmd_ready = 0.
  - cmd_valid during a non-IDLE state: ignored and not consumed.
  - rsp_ready already high when RESP is entered: handshake completes in that same cycle.
  - nreset asserted mid-read: the strobe drops immediately, the pending response is discarded, and no response is issued after reset.
- No bus error or timeout exists; the bus has no wait states.

Optional Feature:
- Macro BUS_CMD_MASTER_WRITE_ACK_EN.
- Defined: a write goes STROBE -> RESP with rsp_rdata = 0 and rsp_is_write = 1, and must be acknowledged via rsp_ready. Write throughput becomes 3 cycles.
- Undefined: writes produce no response and rsp_is_write is tied to 0.

Decomposition:
- Shared package bus_pkg holds:
  - the state encoding (IDLE = 0, STROBE = 1, WAIT = 2, RESP = 3);
  - BUS_ADDR_W = 8 and BUS_DATA_W = 32;
  - register offset constants: CTRL = 0x00, STATE1 = 0x04, STATE2 = 0x08.
- No sub-module is needed: a single FSM with a 4-bit latency counter.

Test Plan:
- Write cmd addr 0x04, wdata 0x80FF0000 -> bus_write_en high exactly one cycle, on the cycle after accept, with bus_addr = 0x04 and bus_write_data = 0x80FF0000; cmd_ready back high 2 cycles after accept.
- Read addr 0x08, slave model registering 0x12345678, READ_LATENCY = 1 then 3 -> rsp_valid with rsp_rdata = 0x12345678 at accept+3 and accept+5 respectively.
- rsp_ready low for 5 cycles after a read -> rsp_valid and rsp_rdata stable, no strobes, cmd_ready = 0; rsp_ready = 1 -> IDLE the next cycle.
- cmd_valid held high with alternating write/read commands -> strobes never overlap, addresses in command order, the bus model sees every command exactly once.
- nreset pulsed during WAIT -> all outputs 0 asynchronously; no rsp_valid after release; next command completes normally.
- With BUS_CMD_MASTER_WRITE_ACK_EN, write to 0x00 -> rsp_valid with rsp_is_write = 1 and rsp_rdata = 0; without the macro, no response.
